// File: rtl/disp_scan_driver_pkg.sv
// rtl/disp_scan_driver_pkg.sv - shared display package: FSM states, segment lookup, digit mapping
package disp_scan_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [2:0] CONV_LAST = 3'd5;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

    // Display registers are packed {d3,d2,d1,d0}: d3/d2 from field_hi, d1/d0 from field_lo
    function automatic logic [15:0] pack_digits(input logic [3:0] hi_tens, input logic [3:0] hi_units,
                                                input logic [3:0] lo_tens, input logic [3:0] lo_units);
        return {hi_tens, hi_units, lo_tens, lo_units};
    endfunction

    function automatic logic [3:0] digit_of(input logic [15:0] disp, input logic [1:0] idx);
        return disp[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/disp_scan_driver_bin.sv
// rtl/disp_scan_driver_bin.sv - bin6_to_bcd: sequential 6-cycle double-dabble converter
module bin6_to_bcd
    import disp_scan_driver_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_start,
    input  logic [5:0] i_bin,
    output logic [3:0] o_tens,
    output logic [3:0] o_units,
    output logic       o_done
);

    logic [7:0] r_bcd;
    logic [2:0] r_cnt;
    logic       r_run;
    logic       w_bit;
    logic [3:0] w_units_adj;
    logic [3:0] w_tens_adj;

    // i_bin must stay stable for the whole run; bits are consumed MSB first
    assign w_bit       = i_bin[3'd5 - r_cnt];
    assign w_units_adj = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
    assign w_tens_adj  = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_bcd <= 8'd0;
            r_cnt <= 3'd0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_bcd <= 8'd0;
            r_cnt <= 3'd0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_bcd <= {w_tens_adj[2:0], w_units_adj, w_bit};
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == CONV_LAST) r_run <= 1'b0;
        end
    end

    // Asserted during the final shift so the parent can leave CONV on that edge
    assign o_done  = r_run && (r_cnt == CONV_LAST);
    assign o_tens  = r_bcd[7:4];
    assign o_units = r_bcd[3:0];

endmodule

// File: rtl/disp_scan_driver.sv
// rtl/disp_scan_driver.sv - 4-digit multiplexed 7-segment scan driver with binary-to-BCD conversion
module disp_scan_driver
    import disp_scan_driver_pkg::*;
#(
    parameter bit BLANK_LEAD = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scan_tick,
    input  logic [5:0] field_hi,
    input  logic [5:0] field_lo,
    input  logic [3:0] digit_en,
    input  logic       colon_in,
    output logic [6:0] segment,
    output logic [3:0] digit_sel,
    output logic       colon_out,
    output logic       busy
);

    state_t     r_state;
    logic       r_busy;
    logic [1:0] r_index;
    logic [5:0] r_shadow_hi;
    logic [5:0] r_shadow_lo;
    logic [15:0] r_disp;
    logic [6:0] r_segment;
    logic [3:0] r_digit_sel;
    logic       r_colon;

    logic [1:0] w_next_index;
    logic       w_frame_start;
    logic       w_start;
    logic       w_en;
    logic       w_blank;
    logic [3:0] w_digit;
    logic [3:0] w_hi_tens, w_hi_units, w_lo_tens, w_lo_units;
    logic       w_hi_done, w_lo_done;

    assign w_next_index  = r_index + 2'd1;
    assign w_frame_start = scan_tick && (r_index == 2'd3);
    assign w_start       = w_frame_start && (r_state == ST_IDLE);
    assign w_en          = digit_en[w_next_index];
    assign w_digit       = digit_of(r_disp, w_next_index);
    assign w_blank       = BLANK_LEAD && (w_next_index == 2'd3) && (r_disp[15:12] == 4'd0);

    bin6_to_bcd u_conv_hi (
        .clock   (clock),
        .reset   (reset),
        .i_start (w_start),
        .i_bin   (r_shadow_hi),
        .o_tens  (w_hi_tens),
        .o_units (w_hi_units),
        .o_done  (w_hi_done)
    );

    bin6_to_bcd u_conv_lo (
        .clock   (clock),
        .reset   (reset),
        .i_start (w_start),
        .i_bin   (r_shadow_lo),
        .o_tens  (w_lo_tens),
        .o_units (w_lo_units),
        .o_done  (w_lo_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_shadow_hi <= 6'd0;
            r_shadow_lo <= 6'd0;
            r_disp      <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_start) begin
                        r_shadow_hi <= field_hi;
                        r_shadow_lo <= field_lo;
                        r_state     <= ST_CONV;
                        r_busy      <= 1'b1;
                    end
                end
                ST_CONV: begin
                    if (w_hi_done && w_lo_done) r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_disp  <= pack_digits(w_hi_tens, w_hi_units, w_lo_tens, w_lo_units);
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs only move on scan_tick; a coincident commit is seen on the following tick
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_index     <= 2'd0;
            r_segment   <= SEG_OFF;
            r_digit_sel <= 4'd0;
            r_colon     <= 1'b0;
        end else if (scan_tick) begin
            r_index     <= w_next_index;
            r_digit_sel <= w_en ? (4'b0001 << w_next_index) : 4'b0000;
            r_segment   <= (w_en && !w_blank) ? seg_encode(w_digit) : SEG_OFF;
            r_colon     <= colon_in && (w_next_index == 2'd2);
        end
    end

    assign segment   = r_segment;
    assign digit_sel = r_digit_sel;
    assign colon_out = r_colon;
    assign busy      = r_busy;

endmodule

// File: doc/disp_scan_driver.md
DISP_SCAN_DRIVER -- requirements
Module: disp_scan_driver

Interface
REQ-001 SHALL have parameter BLANK_LEAD, default 0: when 1, digit 3 is blanked whenever its BCD value is 0.
REQ-002 SHALL have input clock, 1 bit: rising-edge system clock.
REQ-003 SHALL have input reset, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have input scan_tick, 1 bit: single-cycle strobe that advances the scan by one digit.
REQ-005 SHALL have input field_hi, 6 bits: unsigned binary value (0..63) shown on digits 3:2.
REQ-006 SHALL have input field_lo, 6 bits: unsigned binary value (0..63) shown on digits 1:0.
REQ-007 SHALL have input digit_en, 4 bits: per-digit enable mask; bit n enables digit n.
REQ-008 SHALL have input colon_in, 1 bit: colon request.
REQ-009 SHALL have output segment, 7 bits: {g,f,e,d,c,b,a}, active-high, registered.
REQ-010 SHALL have output digit_sel, 4 bits: one-hot-or-zero digit strobe, active-high, registered.
REQ-011 SHALL have output colon_out, 1 bit: colon drive, registered.
REQ-012 SHALL have output busy, 1 bit: high while a conversion is in progress.

Function
REQ-013 SHALL keep a 2-bit scan index that increments by 1 on each scan_tick, wrapping from 3 to 0.
REQ-014 SHALL treat a scan_tick that wraps the index to 0 as a frame start.
REQ-015 On frame start in state IDLE, SHALL capture field_hi and field_lo into shadow registers and enter state CONV.
REQ-016 SHALL use FSM states IDLE, CONV and COMMIT, with transitions IDLE->CONV (frame start), CONV->COMMIT (after 6 cycles) and COMMIT->IDLE (after 1 cycle).
REQ-017 In CONV, SHALL run two parallel shift-add-3 (double-dabble) binary-to-BCD converters, one 6-bit shift per cycle, for exactly 6 cycles.
REQ-018 In COMMIT, SHALL atomically load four 4-bit display registers: d3/d2 = tens/units of field_hi, d1/d0 = tens/units of field_lo.
REQ-019 SHALL make display registers visible 7 cycles after the capture edge, and SHALL never show a partially updated value.
REQ-020 SHALL ignore a frame start that occurs while busy: no capture, conversion continues, and the index still advances.
REQ-021 SHALL convert 60..63 literally (e.g. 63 -> 6,3) with no saturation or error flag.
REQ-022 SHALL drive busy high in CONV and COMMIT and low in IDLE.
REQ-023 On each scan_tick, SHALL register the new index i at the next edge: digit_sel = one-hot(i) if digit_en[i] = 1, else 0000.
REQ-024 On the same edge, SHALL register segment = encode(d_i), or 0000000 if digit i is disabled or blanked.
REQ-025 SHALL use segment encoding 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); BCD 10..15 SHALL encode to 00.
REQ-026 SHALL register colon_out = colon_in AND (new index == 2) on each scan_tick.
REQ-027 Between ticks, segment, digit_sel and colon_out SHALL hold, and COMMIT SHALL NOT alter them until the next scan_tick.
REQ-028 If scan_tick coincides with COMMIT, SHALL encode the segment output from the pre-commit display registers.

Reset
REQ-029 On reset, SHALL set index=0, state=IDLE, busy=0, shadow registers=0, d3..d0=0, segment=0000000, digit_sel=0000 and colon_out=0.
REQ-030 Reset asserted mid-conversion SHALL abort it, and the first frame start after release SHALL start a new capture.
REQ-031 SHALL keep digit_sel at 0000 after reset until the first scan_tick.

Structure
REQ-032 SHALL place FSM state encodings, the segment lookup constants and the digit-index-to-field mapping in the shared display package.
REQ-033 SHALL implement one sub-module, bin6_to_bcd, as a sequential 6-cycle converter instantiated twice, with start/done handshake to the parent FSM.

Verification
REQ-034 Reset release, then 4 scan_ticks with digit_en=1111 and fields 0 -> digit_sel sequence 0010, 0100, 1000, 0001 and segment 3F on each.
REQ-035 field_hi=23, field_lo=59, frame start -> busy high for 7 cycles; the next frame shows digits 2, 3, 5, 9 with segments 5B, 4F, 6D, 6F.
REQ-036 field_lo=63 -> d1=6, d0=3 with segments 7D, 4F; field_hi=0 with BLANK_LEAD=1 -> digit 3 segment 00 while digit_sel still asserts 1000.
REQ-037 Frame start 3 cycles into CONV, with inputs changed to 12/34 -> those inputs are not captured, the old values commit, and the index advances normally.
REQ-038 colon_in=1, digit_en=1011 -> colon_out high only while index 2; at index 2 digit_sel=0000 and segment=00.
REQ-039 Reset asserted at cycle 4 of CONV -> all outputs 0 immediately, busy=0, display registers 0, and recovery after the next frame start.
